csr_access_unit: RTL and testbench

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit.sv | 177 +++++++++++++++++
 tb/tb_csr_access_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// CSR read-modify-write sequencer for the Zicsr instructions targeting fflags/frm/fcsr.
// Optional FPU exception-flag accumulation into fflags is enabled by defining CSR_FFLAGS_ACCUM_EN.
module csr_access_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [4:0]  i_zimm,
  input  logic        i_rs1_zero,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_illegal,
  output logic [11:0] o_csr_addr,
  output logic        o_csr_write,
  output logic [31:0] o_csr_wdata,
  input  logic [31:0] i_csr_rdata,
  input  logic        i_fpu_flags_valid,
  input  logic [4:0]  i_fpu_flags
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned FW   = 5;

  localparam logic [AW-1:0] ADDR_FFLAGS = AW'(12'h001);
  localparam logic [AW-1:0] ADDR_FRM    = AW'(12'h002);
  localparam logic [AW-1:0] ADDR_FCSR   = AW'(12'h003);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]   addr_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] old_q;
  logic            wr_req_q;
  logic            illegal_q;

  logic            accept_c;
  logic            req_illegal_c;
  logic            req_wr_c;
  logic [XLEN-1:0] req_src_c;
  logic [XLEN-1:0] new_c;
  logic            commit_c;
  logic [FW-1:0]   flag_set_c;

  assign accept_c = i_req_valid && o_req_ready;

  // Decode of the incoming request; funct3[1:0]==00 is the reserved encoding.
  assign req_illegal_c = (i_funct3[1:0] == 2'b00) ||
                         !((i_csr_addr == ADDR_FFLAGS) || (i_csr_addr == ADDR_FRM) ||
                           (i_csr_addr == ADDR_FCSR));
  assign req_wr_c      = !req_illegal_c && ((i_funct3[1:0] == 2'b01) || !i_rs1_zero);
  assign req_src_c     = i_funct3[2] ? XLEN'(i_zimm) : i_rs1_data;

  always_comb begin
    new_c = src_q;
    case (op_q)
      2'b10:   new_c = old_q | src_q;
      2'b11:   new_c = old_q & ~src_q;
      default: new_c = src_q;
    endcase
  end

`ifdef CSR_FFLAGS_ACCUM_EN
  logic [FW-1:0] pend_q;
  logic [FW-1:0] flags_in_c;

  assign flags_in_c = i_fpu_flags_valid ? i_fpu_flags : '0;
  assign flag_set_c = pend_q | flags_in_c;
  // Commits only in bus-free states; flags seen in READ/WRITE wait in pend_q.
  assign commit_c   = i_rst_n && ((state_q == IDLE) || (state_q == RESP)) && (flag_set_c != '0);
  assign o_req_ready = (state_q == IDLE) && (pend_q == '0) && !i_fpu_flags_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
    end else if (commit_c) begin
      pend_q <= '0;
    end else begin
      pend_q <= flag_set_c;
    end
  end
`else
  logic unused_fpu;

  assign unused_fpu  = i_fpu_flags_valid ^ (^i_fpu_flags);
  assign flag_set_c  = '0;
  assign commit_c    = 1'b0;
  assign o_req_ready = (state_q == IDLE);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and CSR bus drive; the bus is parked at zero when unused.
  always_comb begin
    state_d     = state_q;
    o_csr_addr  = '0;
    o_csr_write = 1'b0;
    o_csr_wdata = '0;
    case (state_q)
      IDLE: begin
        if (accept_c) state_d = READ;
      end
      READ: begin
        o_csr_addr = addr_q;
        state_d    = wr_req_q ? WRITE : RESP;
      end
      WRITE: begin
        o_csr_addr  = addr_q;
        o_csr_write = 1'b1;
        o_csr_wdata = new_c;
        state_d     = RESP;
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit_c) begin
      o_csr_addr  = ADDR_FFLAGS;
      o_csr_write = 1'b1;
      o_csr_wdata = {{(XLEN-FW){1'b0}}, i_csr_rdata[FW-1:0] | flag_set_c};
    end
  end

  // Request capture on accept, old value capture in READ.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q    <= '0;
      op_q      <= '0;
      src_q     <= '0;
      wr_req_q  <= 1'b0;
      illegal_q <= 1'b0;
      old_q     <= '0;
    end else begin
      if (accept_c) begin
        addr_q    <= i_csr_addr;
        op_q      <= i_funct3[1:0];
        src_q     <= req_src_c;
        wr_req_q  <= req_wr_c;
        illegal_q <= req_illegal_c;
      end
      if (state_q == READ) begin
        old_q <= illegal_q ? '0 : i_csr_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
    end else begin
      o_rsp_valid <= (state_d == RESP);
    end
  end

  assign o_rsp_rdata   = old_q;
  assign o_rsp_illegal = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: directed CSR instructions against a small fflags/frm/fcsr model.
module tb_csr_access_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [2:0]  i_funct3 = '0;
  logic [11:0] i_csr_addr = '0;
  logic [31:0] i_rs1_data = '0;
  logic [4:0]  i_zimm = '0;
  logic        i_rs1_zero = 1'b0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_illegal;
  logic [11:0] o_csr_addr;
  logic        o_csr_write;
  logic [31:0] o_csr_wdata;
  logic [31:0] i_csr_rdata;
  logic        i_fpu_flags_valid = 1'b0;
  logic [4:0]  i_fpu_flags = '0;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ill;
  } rsp_t;

  wr_t  wq[$];
  rsp_t rq[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] fflags_r = 32'h03;
  logic [31:0] frm_r    = 32'h02;
  logic [31:0] fcsr_r   = 32'hE5;

  csr_access_unit dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_funct3         (i_funct3),
    .i_csr_addr       (i_csr_addr),
    .i_rs1_data       (i_rs1_data),
    .i_zimm           (i_zimm),
    .i_rs1_zero       (i_rs1_zero),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (i_rsp_ready),
    .o_rsp_rdata      (o_rsp_rdata),
    .o_rsp_illegal    (o_rsp_illegal),
    .o_csr_addr       (o_csr_addr),
    .o_csr_write      (o_csr_write),
    .o_csr_wdata      (o_csr_wdata),
    .i_csr_rdata      (i_csr_rdata),
    .i_fpu_flags_valid(i_fpu_flags_valid),
    .i_fpu_flags      (i_fpu_flags)
  );

  always #5 i_clk = ~i_clk;

  // CSR register file model: combinational read, write on the clock edge.
  always_comb begin
    case (o_csr_addr)
      12'h001: i_csr_rdata = fflags_r;
      12'h002: i_csr_rdata = frm_r;
      12'h003: i_csr_rdata = fcsr_r;
      default: i_csr_rdata = 32'h0;
    endcase
  end

  always @(posedge i_clk) begin
    if (o_csr_write) begin
      case (o_csr_addr)
        12'h001: fflags_r <= o_csr_wdata;
        12'h002: frm_r    <= o_csr_wdata;
        12'h003: fcsr_r   <= o_csr_wdata;
        default: ;
      endcase
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every write strobe and every completed response must match the queues.
  always @(negedge i_clk) begin
    wr_t  w;
    rsp_t r;
    if (o_csr_write) begin
      chk("write_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("write_addr", 32'(o_csr_addr), 32'(w.addr));
        chk("write_data", o_csr_wdata, w.data);
      end
    end
    if (o_rsp_valid && i_rsp_ready) begin
      chk("rsp_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("rsp_rdata", o_rsp_rdata, r.rdata);
        chk("rsp_illegal", 32'(o_rsp_illegal), 32'(r.ill));
      end
    end
  end

  task automatic do_req(input string name, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] zimm, input logic rz,
                        input logic [31:0] exp_rd, input logic exp_ill, input logic exp_wr,
                        input logic [31:0] exp_wd, input int exp_lat, input int hold);
    int lat;
    chk({name, "_ready"}, 32'(o_req_ready), 32'd1);
    if (exp_wr) wq.push_back('{addr: addr, data: exp_wd});
    rq.push_back('{rdata: exp_rd, ill: exp_ill});
    i_req_valid = 1'b1;
    i_funct3    = f3;
    i_csr_addr  = addr;
    i_rs1_data  = rs1;
    i_zimm      = zimm;
    i_rs1_zero  = rz;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge i_clk); #1;
      lat++;
    end while (!o_rsp_valid && lat < 8);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      chk({name, "_hold_valid"}, 32'(o_rsp_valid), 32'd1);
      chk({name, "_hold_rdata"}, o_rsp_rdata, exp_rd);
      chk({name, "_hold_ill"}, 32'(o_rsp_illegal), 32'(exp_ill));
      @(posedge i_clk); #1;
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_rsp_ill", 32'(o_rsp_illegal), 32'd0);
    chk("rst_csr_write", 32'(o_csr_write), 32'd0);
    chk("rst_csr_addr", 32'(o_csr_addr), 32'd0);
    chk("rst_csr_wdata", o_csr_wdata, 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    chk("rel_ready", 32'(o_req_ready), 32'd1);

    do_req("rs_fflags",  3'b010, 12'h001, 32'h10, 5'h00, 1'b0, 32'h03, 1'b0, 1'b1, 32'h13, 2, 0);
    do_req("rci_fcsr",   3'b111, 12'h003, 32'h00, 5'h05, 1'b0, 32'hE5, 1'b0, 1'b1, 32'hE0, 2, 0);
    do_req("rsi_x0_frm", 3'b110, 12'h002, 32'h00, 5'h00, 1'b1, 32'h02, 1'b0, 1'b0, 32'h00, 1, 0);
    do_req("ill_addr",   3'b001, 12'h300, 32'h77, 5'h00, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1, 3);
    do_req("ill_f3_100", 3'b100, 12'h001, 32'h77, 5'h03, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1, 3);
    do_req("rw_frm",     3'b001, 12'h002, 32'h01, 5'h00, 1'b0, 32'h02, 1'b0, 1'b1, 32'h01, 2, 2);
    do_req("rwi_zero",   3'b101, 12'h002, 32'h00, 5'h00, 1'b1, 32'h01, 1'b0, 1'b1, 32'h00, 2, 0);
    do_req("rc_x0",      3'b011, 12'h001, 32'h03, 5'h00, 1'b1, 32'h13, 1'b0, 1'b0, 32'h00, 1, 0);
    do_req("rc_fflags",  3'b011, 12'h001, 32'h03, 5'h00, 1'b0, 32'h13, 1'b0, 1'b1, 32'h10, 2, 0);
    do_req("ill_f3_000", 3'b000, 12'h002, 32'h01, 5'h00, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1, 0);
    do_req("rw_fflags",  3'b001, 12'h001, 32'h02, 5'h00, 1'b0, 32'h10, 1'b0, 1'b1, 32'h02, 2, 0);

`ifdef CSR_FFLAGS_ACCUM_EN
    fork
      do_req("fl_rw_fcsr", 3'b001, 12'h003, 32'h55, 5'h00, 1'b0, 32'hE0, 1'b0, 1'b1, 32'h55, 2, 0);
      begin
        @(posedge i_clk); #1;
        wq.push_back('{addr: 12'h001, data: 32'h13});
        i_fpu_flags_valid = 1'b1;
        i_fpu_flags       = 5'h01;
        @(posedge i_clk); #1;
        i_fpu_flags       = 5'h10;
        chk("fl_ready_write", 32'(o_req_ready), 32'd0);
        @(posedge i_clk); #1;
        i_fpu_flags_valid = 1'b0;
        i_fpu_flags       = 5'h00;
        chk("fl_ready_resp", 32'(o_req_ready), 32'd0);
        chk("fl_commit_strobe", 32'(o_csr_write), 32'd1);
      end
    join
    chk("fl_ready_cleared", 32'(o_req_ready), 32'd1);
    wq.push_back('{addr: 12'h001, data: 32'h17});
    i_fpu_flags_valid = 1'b1;
    i_fpu_flags       = 5'h04;
    #1;
    chk("fl_idle_ready", 32'(o_req_ready), 32'd0);
    @(posedge i_clk); #1;
    i_fpu_flags_valid = 1'b0;
    i_fpu_flags       = 5'h00;
    chk("fl_idle_ready_after", 32'(o_req_ready), 32'd1);
`else
    i_fpu_flags_valid = 1'b1;
    i_fpu_flags       = 5'h1F;
    #1;
    chk("nofl_ready", 32'(o_req_ready), 32'd1);
    repeat (2) @(posedge i_clk);
    #1;
    chk("nofl_ready_after", 32'(o_req_ready), 32'd1);
    i_fpu_flags_valid = 1'b0;
    i_fpu_flags       = 5'h00;
`endif

    // Reset in the middle of a write: no strobe, no response.
    i_req_valid = 1'b1;
    i_funct3    = 3'b001;
    i_csr_addr  = 12'h003;
    i_rs1_data  = 32'hAA;
    i_rs1_zero  = 1'b0;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_write", 32'(o_csr_write), 32'd0);
    chk("mid_rst_addr", 32'(o_csr_addr), 32'd0);
    chk("mid_rst_wdata", o_csr_wdata, 32'd0);
    chk("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("mid_rst_rdata", o_rsp_rdata, 32'd0);
    chk("mid_rst_ill", 32'(o_rsp_illegal), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("post_rst_ready", 32'(o_req_ready), 32'd1);
    repeat (3) @(posedge i_clk);
    #1;
    chk("post_rst_no_rsp", 32'(o_rsp_valid), 32'd0);
    chk("fcsr_untouched", fcsr_r, 32'h55 ^ 32'h55 ^ fcsr_expected());
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [31:0] fcsr_expected();
`ifdef CSR_FFLAGS_ACCUM_EN
    return 32'h55;
`else
    return 32'hE0;
`endif
  endfunction

endmodule
